toycpu_seq: RTL and testbench
=============================

# toycpu_seq

Multi-cycle control sequencer for the toy CPU. It owns the PC, instruction register (IR), memory data register (MDR) and C/Z flags. It drives the single shared memory port through a req/ack handshake, alternating between instruction fetch and LD/ST data access. The combinational instruction decoder sits between IR and this block: it reads `ir`, the block consumes the decoder's control outputs, and the block qualifies register-file writes in time.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded at reset
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `run`  in  1  level; 1 = execute instructions, 0 = park in IDLE at the next instruction boundary
- `mem_req`  out  1  memory request, held until `mem_ack`
- `mem_we`  out  1  1 = write, 0 = read; stable while `mem_req`
- `mem_addr`  out  16  word address; stable while `mem_req`
- `mem_wdata`  out  16  store data; stable while `mem_req`
- `mem_rdata`  in  16  read data, valid in the `mem_ack` cycle
- `mem_ack`  in  1  one-cycle completion pulse; ignored when `mem_req`=0
- `ir`  out  16  instruction register, drives the decoder
- `pc`  out  16  program counter
- `dec_next_pc_sel`  in  2  decoder nextPCSel
- `dec_mem_we`, `dec_daddr_sel`, `dec_reg_data_in_src`, `dec_reg_file_we`  in  1 each  decoder control outputs
- `dec_instr_data`  in  16  decoder sign/zero-extended payload
- `reg_src1_data`  in  16  register file port 1 (indirect address)
- `reg_src2_data`  in  16  register file port 2 (store data)
- `alu_c`, `alu_z`  in  1 each  ALU flag results
- `c_flag`, `z_flag`  out  1 each  registered flags, fed back to the decoder
- `rf_we`  out  1  qualified register-file write strobe
- `mdr`  out  16  latched load data for register write-back
- `instret`  out  16  retired-instruction counter, wraps at 16'hFFFF -> 0
- `halted`  out  1  HALT state indicator (0 when TOYCPU_HALT_EN is undefined)

## Operation
- **States:** IDLE, FETCH, EXEC, MEM, WB, HALT.
- **IDLE:** no request.
  - `run`=1 -> FETCH.
- **FETCH:** `mem_req`=1, `mem_we`=0, `mem_addr`=`pc`.
  - On `mem_ack`: IR <= `mem_rdata`; go to EXEC.
- **EXEC (exactly one cycle):** the decoder is combinational on IR.
  - **PC update:** if `dec_next_pc_sel`==2'b01, PC <= PC + `dec_instr_data` (16-bit, wraps). Otherwise PC <= PC + 1 (wraps).
  - **Opcode 000 (ALU):** `rf_we`=1; C/Z <= `alu_c`/`alu_z`.
  - **Opcode 001 (LD immediate):** `rf_we`=1; flags unchanged.
  - **Opcodes 011 and 101 (LD/ST indirect):** go to MEM.
  - **Opcode 110 (branch):** no write.
  - **Opcodes 010 and 100:** NOP.
  - **Opcode 111:** HALT if TOYCPU_HALT_EN is defined, else NOP.
  - **Exit (non-MEM opcodes):** `instret`++; next state is FETCH if `run`=1, else IDLE.
- **MEM:** `mem_req`=1, `mem_addr`=`reg_src1_data`, `mem_we`=`dec_mem_we`, `mem_wdata`=`reg_src2_data`.
  - On `mem_ack` for a load: MDR <= `mem_rdata`; go to WB.
  - On `mem_ack` for a store: `instret`++; go to FETCH/IDLE.
- **WB (one cycle):** `rf_we`=1 (register-file data source = MDR via `dec_reg_data_in_src`); `instret`++; go to FETCH/IDLE.
- **`rf_we` gating:** asserted only in EXEC (opcode 000/001) and WB. It never follows `dec_reg_file_we` in any other state.
- **`run` deasserted mid-instruction:** the instruction completes normally; the block stops only at the boundary.
- **HALT:** absorbing. `halted`=1, no requests; exit only through `rst_n`.

## Timing
- **Reset values:**
  - state=IDLE, `pc`=RESET_PC, `ir`=0, `mdr`=0.
  - `c_flag`=`z_flag`=0, `instret`=0.
  - `mem_req`=`mem_we`=`rf_we`=`halted`=0; `mem_addr`=`mem_wdata`=0.
- **Reset assertion:** asynchronous, takes effect immediately. A pending `mem_req` drops in the same instant; the memory must discard the transaction.
- **Outputs:** `mem_*` and `rf_we` are decoded from registered state (Moore-style) plus stable registered/decoder inputs.
- **Handshake:** `mem_ack` arriving in the same cycle as `mem_req` first rises is accepted (zero-wait).
- **Cycles per instruction, w = memory wait cycles (ack arrives w cycles after req; zero-wait = 0):**
  - ALU/LD-imm/branch/NOP: 2+w.
  - ST: 3+2w.
  - LD indirect: 4+2w.
- **Flag timing:** updated flags are visible to the decoder from the next instruction's EXEC onward. A branch that follows an ALU op sees the new flags.

## Configuration
- **TOYCPU_HALT_EN defined:** opcode 3'b111 enters HALT after EXEC. PC still advances by 1 and `instret` counts the halt instruction.
- **Undefined:** 3'b111 is a NOP, and `halted` is tied to 0.

## Structure
- **Shared package `toycpu_pkg`:**
  - Opcode localparams: OP_ALU=3'b000, OP_LDI=3'b001, OP_LD=3'b011, OP_ST=3'b101, OP_BR=3'b110, OP_HLT=3'b111.
  - State enum `seq_state_t`.
  - NEXTPC_BRANCH=2'b01.
- **Submodules:** none required. The `instret` counter is the one natural sub-module, `toycpu_counter` (16-bit, enable, wrap), which can be reused.

## Test plan
- **Reset/zero-wait fetch:** reset with RESET_PC=16'h0010, `run`=1, zero-wait memory, mem[0x10]=16'h0000 (ALU op), `alu_z`=1 -> `mem_addr`=0x10 in the first FETCH; `rf_we` pulses 2 cycles later; `z_flag`=1; `pc`=0x11; `instret`=1.
- **Branch wrap:** taken branch at PC=0x0002 with payload 8'hFE (`dec_instr_data`=16'hFFFE) -> `pc`=0x0000. An untaken branch at PC=0xFFFF -> `pc`=0x0000.
- **Indirect load, 3 wait cycles:** `reg_src1_data`=0x0040, mem[0x40]=16'hBEEF -> MEM `mem_addr`=0x40, `mem_we`=0; `mdr`=16'hBEEF; `rf_we` high exactly 1 cycle in WB; total 10 cycles.
- **Store:** `reg_src1_data`=0x0080, `reg_src2_data`=16'h1234 -> `mem_we`=1, `mem_addr`=0x80, `mem_wdata`=0x1234, all stable across 2 wait cycles; `rf_we` never asserted.
- **Mid-operation events:** `run` dropped during a 5-wait-cycle LD -> the load completes and the block enters IDLE with `mem_req`=0. `rst_n` pulsed during FETCH wait -> `mem_req` low immediately and `pc`=RESET_PC.
- **HALT:** with TOYCPU_HALT_EN, fetch 16'hE000 -> `halted`=1 two cycles after ack, no further `mem_req`. Without the macro, the same instruction -> `pc`+1 and the next fetch proceeds.

Source files
------------

// File: rtl/toycpu_pkg.sv
// toycpu_pkg: opcodes, sequencer states and helpers shared by the toy CPU.
// Consumed by toycpu_seq and toycpu_counter.
package toycpu_pkg;

  localparam logic [2:0] OP_ALU = 3'b000;
  localparam logic [2:0] OP_LDI = 3'b001;
  localparam logic [2:0] OP_LD  = 3'b011;
  localparam logic [2:0] OP_ST  = 3'b101;
  localparam logic [2:0] OP_BR  = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  localparam logic [1:0] NEXTPC_BRANCH = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } seq_state_t;

  function automatic logic [2:0] opcodeOf(
    input logic [15:0] instr
  );
    return instr[15:13];
  endfunction

endpackage

// File: rtl/toycpu_counter.sv
// toycpu_counter: free-running up counter with enable.
// Wraps from all-ones back to zero.
module toycpu_counter
  import toycpu_pkg::*;
#(
  parameter int Width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [Width-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= count + Width'(1);
    end
  end

endmodule

// File: rtl/toycpu_seq.sv
// toycpu_seq: multi-cycle fetch/exec/mem/wb sequencer of the toy CPU.
// Define TOYCPU_HALT_EN to make opcode 3'b111 park the core in HALT.
module toycpu_seq
  import toycpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] ir,
  output logic [15:0] pc,
  input  logic [1:0]  dec_next_pc_sel,
  input  logic        dec_mem_we,
  input  logic        dec_daddr_sel,
  input  logic        dec_reg_data_in_src,
  input  logic        dec_reg_file_we,
  input  logic [15:0] dec_instr_data,
  input  logic [15:0] reg_src1_data,
  input  logic [15:0] reg_src2_data,
  input  logic        alu_c,
  input  logic        alu_z,
  output logic        c_flag,
  output logic        z_flag,
  output logic        rf_we,
  output logic [15:0] mdr,
  output logic [15:0] instret,
  output logic        halted
);

  seq_state_t state;
  seq_state_t nextState;
  seq_state_t boundary;

  logic [2:0]  op;
  logic [15:0] pcNext;
  logic        irLoad;
  logic        mdrLoad;
  logic        pcLoad;
  logic        flagsLoad;
  logic        retire;
  logic        unusedDec;

`ifdef TOYCPU_HALT_EN
  localparam bit HaltEn = 1'b1;
  assign halted = (state == S_HALT);
`else
  localparam bit HaltEn = 1'b0;
  assign halted = 1'b0;
`endif

  // These decoder outputs steer the register file, not the sequencer.
  assign unusedDec = ^{dec_daddr_sel, dec_reg_data_in_src, dec_reg_file_we};

  assign op = opcodeOf(ir);
  assign boundary = run ? S_FETCH : S_IDLE;
  assign pcNext = (dec_next_pc_sel == NEXTPC_BRANCH)
                ? pc + dec_instr_data
                : pc + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    rf_we     = 1'b0;
    irLoad    = 1'b0;
    mdrLoad   = 1'b0;
    pcLoad    = 1'b0;
    flagsLoad = 1'b0;
    retire    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (run) nextState = S_FETCH;
      end
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_ack) begin
          irLoad    = 1'b1;
          nextState = S_EXEC;
        end
      end
      S_EXEC: begin
        pcLoad    = 1'b1;
        retire    = 1'b1;
        nextState = boundary;
        case (op)
          OP_ALU: begin
            rf_we     = 1'b1;
            flagsLoad = 1'b1;
          end
          OP_LDI: rf_we = 1'b1;
          OP_LD, OP_ST: begin
            retire    = 1'b0;
            nextState = S_MEM;
          end
          OP_BR: nextState = boundary;
          OP_HLT: begin
            if (HaltEn) nextState = S_HALT;
          end
          default: nextState = boundary;
        endcase
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_we    = dec_mem_we;
        mem_addr  = reg_src1_data;
        mem_wdata = reg_src2_data;
        if (mem_ack) begin
          if (dec_mem_we) begin
            retire    = 1'b1;
            nextState = boundary;
          end else begin
            mdrLoad   = 1'b1;
            nextState = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we     = 1'b1;
        retire    = 1'b1;
        nextState = boundary;
      end
      S_HALT: nextState = S_HALT;
      default: nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      ir     <= 16'h0000;
      mdr    <= 16'h0000;
      c_flag <= 1'b0;
      z_flag <= 1'b0;
    end else begin
      if (irLoad) ir <= mem_rdata;
      if (mdrLoad) mdr <= mem_rdata;
      if (pcLoad) pc <= pcNext;
      if (flagsLoad) begin
        c_flag <= alu_c;
        z_flag <= alu_z;
      end
    end
  end

  toycpu_counter #(
    .Width(16)
  ) instretCnt (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (retire),
    .count(instret)
  );

endmodule

// File: tb/tb_toycpu_seq.sv
// tb_toycpu_seq: random program run against an instruction-level model.
// Honours TOYCPU_HALT_EN the same way the design does.
module tb_toycpu_seq;
  import toycpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_ack = 1'b0;
  logic [15:0] ir, pc;
  logic [1:0]  dec_next_pc_sel;
  logic        dec_mem_we, dec_daddr_sel;
  logic        dec_reg_data_in_src, dec_reg_file_we;
  logic [15:0] dec_instr_data;
  logic [15:0] reg_src1_data, reg_src2_data;
  logic        alu_c, alu_z;
  logic        c_flag, z_flag, rf_we;
  logic [15:0] mdr, instret;
  logic        halted;

  always #5 clk = ~clk;

  toycpu_seq #(
    .RESET_PC(16'h0010)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .run                (run),
    .mem_req            (mem_req),
    .mem_we             (mem_we),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_rdata          (mem_rdata),
    .mem_ack            (mem_ack),
    .ir                 (ir),
    .pc                 (pc),
    .dec_next_pc_sel    (dec_next_pc_sel),
    .dec_mem_we         (dec_mem_we),
    .dec_daddr_sel      (dec_daddr_sel),
    .dec_reg_data_in_src(dec_reg_data_in_src),
    .dec_reg_file_we    (dec_reg_file_we),
    .dec_instr_data     (dec_instr_data),
    .reg_src1_data      (reg_src1_data),
    .reg_src2_data      (reg_src2_data),
    .alu_c              (alu_c),
    .alu_z              (alu_z),
    .c_flag             (c_flag),
    .z_flag             (z_flag),
    .rf_we              (rf_we),
    .mdr                (mdr),
    .instret            (instret),
    .halted             (halted)
  );

  // Stub decoder, register file and ALU, all driven from IR bits.
  logic [2:0] bop;
  assign bop = ir[15:13];

  always_comb begin
    dec_next_pc_sel = {ir[10], ir[10] & ir[11]};
    if (bop == OP_BR)
      dec_next_pc_sel = (ir[9] | (ir[8] ? z_flag : c_flag))
                      ? NEXTPC_BRANCH : 2'b00;
    dec_mem_we          = (bop == OP_ST);
    dec_daddr_sel       = (bop == OP_LD) || (bop == OP_ST);
    dec_reg_data_in_src = (bop == OP_LD);
    dec_reg_file_we     = (bop != OP_ST) && (bop != OP_BR);
    dec_instr_data      = {{8{ir[7]}}, ir[7:0]};
    reg_src1_data       = {4'h0, ir[11:0]};
    reg_src2_data       = ir ^ 16'hB2B4;
    alu_c               = ir[0];
    alu_z               = ~ir[1];
  end

  typedef struct {
    bit          req;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    bit          rfwe;
    logic [15:0] pc;
    logic [15:0] ir;
    bit          c;
    bit          z;
    logic [15:0] ins;
    logic [15:0] mdr;
    bit          halt;
    bit          run;
  } rec_t;

  rec_t        trace[$];
  int          waits[$];
  logic [15:0] fetchPcs[$];
  logic [15:0] mem [0:65535];
  logic [15:0] mm  [0:65535];

  logic [15:0] mPc, mIr, mIns, mMdr;
  bit          mC, mZ, mHalt;

  int nCmp = 0;
  int nBad = 0;

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h want %h @%0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: ack after the scheduled number of wait cycles.
  int cnt = 0;
  int accIdx = 0;
  always @(negedge clk) begin
    int w;
    w = (accIdx < waits.size()) ? waits[accIdx] : 1 << 30;
    mem_rdata = 16'($urandom);
    if (!rst_n || !mem_req) begin
      mem_ack = 1'b0;
      cnt = 0;
    end else if (cnt >= w) begin
      mem_ack = 1'b1;
      cnt = 0;
      accIdx++;
      if (mem_we) mem[mem_addr] = mem_wdata;
      else mem_rdata = mem[mem_addr];
    end else begin
      mem_ack = 1'b0;
      cnt++;
    end
  end

  task automatic push(input bit req, input bit we, input logic [15:0] a,
                      input logic [15:0] d, input bit rfwe, input bit rn);
    rec_t r;
    r.req = req; r.we = we; r.addr = a; r.wdata = d; r.rfwe = rfwe;
    r.pc = mPc; r.ir = mIr; r.c = mC; r.z = mZ; r.ins = mIns;
    r.mdr = mMdr; r.halt = mHalt; r.run = rn;
    trace.push_back(r);
  endtask

  function automatic int nextWait();
    int forced[5] = '{0, 3, 3, 2, 2};
    int r;
    if (waits.size() < 5) return forced[waits.size()];
    r = $urandom_range(0, 9);
    if (r < 4) return 0;
    if (r < 8) return $urandom_range(1, 3);
    return 5;
  endfunction

  task automatic setWord(input logic [15:0] a, input logic [15:0] d);
    mem[a] = d;
    mm[a] = d;
  endtask

  // Instruction-level model expanded into an expected per-cycle trace.
  task automatic buildModel();
    mPc = 16'h0010; mIr = 0; mIns = 0; mMdr = 0;
    mC = 0; mZ = 0; mHalt = 0;
    push(0, 0, 0, 0, 0, 1);
    for (int k = 0; ; k++) begin
      bit last, stop, bnd, memOp, st, taken;
      logic [2:0] op;
      logic [15:0] a, d;
      int w;
      last = trace.size() > 20000;
      stop = last || (k >= 10 && $urandom_range(0, 15) == 0);
      bnd = !stop;
      fetchPcs.push_back(mPc);
      w = nextWait();
      waits.push_back(w);
      for (int i = 0; i <= w; i++)
        push(1, 0, mPc, 0, 0, 1'($urandom));
      mIr = mm[mPc];
      op = mIr[15:13];
      memOp = (op == OP_LD) || (op == OP_ST);
      push(0, 0, 0, 0, (op == OP_ALU) || (op == OP_LDI),
           memOp ? 1'($urandom) : bnd);
      taken = (op == OP_BR) && (mIr[9] || (mIr[8] ? mZ : mC));
      mPc = taken ? mPc + {{8{mIr[7]}}, mIr[7:0]} : mPc + 16'd1;
      if (op == OP_ALU) begin
        mC = mIr[0];
        mZ = ~mIr[1];
      end
      if (memOp) begin
        a = {4'h0, mIr[11:0]};
        st = (op == OP_ST);
        d = mIr ^ 16'hB2B4;
        w = nextWait();
        waits.push_back(w);
        for (int i = 0; i <= w; i++)
          push(1, st, a, d, 0, (i == w && st) ? bnd : 1'($urandom));
        if (st) begin
          mm[a] = d;
        end else begin
          mMdr = mm[a];
          push(0, 0, 0, 0, 1, bnd);
        end
      end
      mIns++;
`ifdef TOYCPU_HALT_EN
      if (op == OP_HLT) begin
        mHalt = 1;
        repeat (6) push(0, 0, 0, 0, 0, 1'($urandom));
        break;
      end
`endif
      if (stop) begin
        repeat ($urandom_range(1, 3)) push(0, 0, 0, 0, 0, 0);
        if (last) break;
        push(0, 0, 0, 0, 0, 1);
      end
    end
  endtask

  initial begin
    logic [15:0] w16;
    logic [15:0] expPcs[10] = '{16'h0010, 16'h0011, 16'h0012, 16'h0013,
                               16'hFFFF, 16'h0000, 16'h0001, 16'h0002,
                               16'h0000, 16'h0020};
    rec_t r;
    for (int i = 0; i < 65536; i++) begin
      w16 = 16'($urandom);
      if (w16[15:13] == OP_HLT && $urandom_range(0, 15) != 0)
        w16[15:13] = 3'b010;
      setWord(16'(i), w16);
    end
    setWord(16'h0010, 16'h0000);
    setWord(16'h0011, 16'h6040);
    setWord(16'h0012, 16'hA080);
    setWord(16'h0013, 16'hC2EC);
    setWord(16'hFFFF, 16'hC005);
    setWord(16'h0000, 16'hC020);
    setWord(16'h0001, 16'h0001);
    setWord(16'h0002, 16'hC0FE);
    setWord(16'h0040, 16'hBEEF);
    buildModel();

    for (int i = 0; i < 10; i++)
      if (i < fetchPcs.size())
        chk($sformatf("model_fetch_pc%0d", i), fetchPcs[i], expPcs[i]);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_pc", pc, 16'h0010);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_instret", instret, 16'h0000);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_halted", halted, 1'b0);

    for (int i = 0; i < trace.size(); i++) begin
      r = trace[i];
      chk("mem_req", mem_req, r.req);
      if (r.req) begin
        chk("mem_addr", mem_addr, r.addr);
        chk("mem_we", mem_we, r.we);
        if (r.we) chk("mem_wdata", mem_wdata, r.wdata);
      end
      chk("rf_we", rf_we, r.rfwe);
      chk("pc", pc, r.pc);
      chk("ir", ir, r.ir);
      chk("c_flag", c_flag, r.c);
      chk("z_flag", z_flag, r.z);
      chk("instret", instret, r.ins);
      chk("mdr", mdr, r.mdr);
      chk("halted", halted, r.halt);
      case (i)
        1: chk("lit_fetch_addr", mem_addr, 16'h0010);
        2: chk("lit_alu_rfwe", rf_we, 1'b1);
        3: begin
          chk("lit_pc_after_alu", pc, 16'h0011);
          chk("lit_z_after_alu", z_flag, 1'b1);
          chk("lit_instret1", instret, 16'h0001);
        end
        12: begin
          chk("lit_mdr", mdr, 16'hBEEF);
          chk("lit_wb_rfwe", rf_we, 1'b1);
        end
        13: chk("lit_instret2", instret, 16'h0002);
        18: begin
          chk("lit_st_addr", mem_addr, 16'h0080);
          chk("lit_st_wdata", mem_wdata, 16'h1234);
          chk("lit_st_we", mem_we, 1'b1);
        end
        default: ;
      endcase
      run = r.run;
      if (nBad > 40) break;
      @(negedge clk);
    end

    if (!mHalt) begin
      run = 1'b1;
      @(negedge clk);
      chk("end_fetch_req", mem_req, 1'b1);
      chk("end_fetch_addr", mem_addr, mPc);
      @(negedge clk);
      chk("end_fetch_wait", mem_req, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_req", mem_req, 1'b0);
      chk("async_rst_pc", pc, 16'h0010);
      chk("async_rst_instret", instret, 16'h0000);
    end else begin
      repeat (20) begin
        @(negedge clk);
        chk("halt_no_req", mem_req, 1'b0);
        chk("halt_sticky", halted, 1'b1);
      end
      #2 rst_n = 1'b0;
      #1;
      chk("halt_rst", halted, 1'b0);
      chk("halt_rst_pc", pc, 16'h0010);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
